// File: rtl/seed_pkg.sv
// Shared sizing and state encoding for the SEED round sequencer.
package seed_pkg;

   localparam int NUM_ROUNDS = 16;
   localparam int CNT_W      = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ROUND = 3'd2,
      FINAL = 3'd3,
      HOLD  = 3'd4
   } state_t;

endpackage

// File: rtl/seed_round_ctrl.sv
// SEED round sequencer: takes one block job and steps one Feistel round per clk_en pulse,
// then holds the result valid until the host takes it.
module seed_round_ctrl #(
   parameter int NUM_ROUNDS = seed_pkg::NUM_ROUNDS,
   parameter int CNT_W      = seed_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             decrypt,
   input  logic             clk_en,
   output logic             run,
   output logic             load_blk,
   output logic             round_step,
   output logic [CNT_W-1:0] round_idx,
   output logic [CNT_W-1:0] key_idx,
   output logic             final_swap,
   output logic             out_valid,
   input  logic             out_ready
);

   import seed_pkg::*;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] round_idx_reg, round_idx_next;
   logic             mode_reg, mode_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         round_idx_reg <= '0;
         mode_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         round_idx_reg <= round_idx_next;
         mode_reg      <= mode_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      round_idx_next = round_idx_reg;
      mode_next      = mode_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               mode_next      = decrypt;
               round_idx_next = '0;
               state_next     = LOAD;
            end
         end
         LOAD: state_next = ROUND;
         ROUND: begin
            // The last round keeps its index so key_idx stays in range through FINAL/HOLD.
            if (clk_en) begin
               if (round_idx_reg == LAST_IDX) state_next = FINAL;
               else round_idx_next = round_idx_reg + 1'b1;
            end
         end
         FINAL: begin
            if (clk_en) state_next = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               state_next     = IDLE;
               round_idx_next = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      run        = 1'b0;
      load_blk   = 1'b0;
      round_step = 1'b0;
      final_swap = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE:  in_ready = 1'b1;
         LOAD:  load_blk = 1'b1;
         ROUND: begin
            run        = 1'b1;
            round_step = clk_en;
         end
         FINAL: begin
            run        = 1'b1;
            final_swap = clk_en;
         end
         HOLD:  out_valid = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   assign round_idx = round_idx_reg;
   // round_idx never exceeds LAST_IDX, so the reversal cannot underflow.
   assign key_idx   = mode_reg ? (LAST_IDX - round_idx_reg) : round_idx_reg;

endmodule

// File: tb/tb_seed_round_ctrl.sv
// Randomized self-checking bench for seed_round_ctrl with a behavioural clk_en generator.
module tb_seed_round_ctrl;

   localparam int NR = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          decrypt = 1'b0;
   logic          out_ready = 1'b0;
   logic          noise = 1'b0;
   logic          noise_on = 1'b1;
   logic          in_ready, run, load_blk, round_step, final_swap, out_valid;
   logic [CW-1:0] round_idx, key_idx;
   logic [1:0]    gen_cnt;
   logic          clk_en;

   int total = 0;
   int bad = 0;
   int loads = 0, steps = 0, swaps = 0;
   int key_q[$];
   int idx_q[$];

   seed_round_ctrl dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .decrypt(decrypt), .clk_en(clk_en), .run(run), .load_blk(load_blk),
      .round_step(round_step), .round_idx(round_idx), .key_idx(key_idx),
      .final_swap(final_swap), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Generator: counter pauses while run is low, pulses every 4th running cycle.
   always @(posedge clk or posedge reset) begin
      if (reset) gen_cnt <= 2'd0;
      else if (run) gen_cnt <= gen_cnt + 2'd1;
   end
   assign clk_en = run ? (gen_cnt == 2'd3) : noise;

   // Stray strobes while the sequencer is not running must be ignored.
   initial forever begin
      @(posedge clk);
      #1;
      noise = noise_on & ($urandom_range(0, 1) == 1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a job is "loading" for one cycle, then consumes NR+1 clk_en pulses, then waits.
   initial begin
      bit m_busy, m_load, m_mode, running, holding;
      int m_pulses, e_idx, e_key;
      m_busy = 0; m_load = 0; m_mode = 0; m_pulses = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("rst_in_ready", in_ready, 1);
            check("rst_run", run, 0);
            check("rst_strobes", {load_blk, round_step, final_swap}, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_round_idx", round_idx, 0);
            check("rst_key_idx", key_idx, 0);
            m_busy = 0; m_load = 0; m_mode = 0; m_pulses = 0;
         end else begin
            running = m_busy && !m_load && (m_pulses <= NR);
            holding = m_busy && !m_load && (m_pulses > NR);
            e_idx   = (!m_busy || m_load) ? 0 : ((m_pulses < NR) ? m_pulses : NR - 1);
            e_key   = m_mode ? (NR - 1 - e_idx) : e_idx;
            check("in_ready", in_ready, !m_busy);
            check("run", run, running);
            check("load_blk", load_blk, m_busy && m_load);
            check("round_step", round_step, running && clk_en && (m_pulses < NR));
            check("final_swap", final_swap, running && clk_en && (m_pulses == NR));
            check("out_valid", out_valid, holding);
            check("round_idx", round_idx, e_idx);
            check("key_idx", key_idx, e_key);
            check("strobe_excl", ($countones({load_blk, round_step, final_swap}) <= 1), 1);
            if (load_blk) loads++;
            if (final_swap) swaps++;
            if (round_step) begin
               steps++;
               key_q.push_back(int'(key_idx));
               idx_q.push_back(int'(round_idx));
            end
            if (!m_busy) begin
               if (in_valid) begin
                  m_busy = 1; m_load = 1; m_pulses = 0; m_mode = decrypt;
               end
            end else if (m_load) begin
               m_load = 0;
            end else if (running) begin
               if (clk_en) m_pulses++;
            end else if (out_ready) begin
               m_busy = 0;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic submit(input bit dec);
      int n = 0;
      while (!in_ready && n < 200) begin tick(1); n++; end
      if (!in_ready) check("timeout_in_ready", 0, 1);
      in_valid = 1'b1;
      decrypt  = dec;
      tick(1);
      in_valid = 1'b0;
      decrypt  = ~dec;
   endtask

   task automatic wait_ov();
      int n = 0;
      while (!out_valid && n < 300) begin tick(1); n++; end
      if (!out_valid) check("timeout_out_valid", 0, 1);
   endtask

   task automatic check_seq(input bit dec);
      check("steps_per_job", key_q.size(), NR);
      for (int i = 0; i < NR && i < key_q.size(); i++) begin
         check("key_seq", key_q[i], dec ? NR - 1 - i : i);
         check("idx_seq", idx_q[i], i);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int l0, s0, w0, n;
      bit dec;
      tick(3);
      reset = 1'b0;

      // Idle with stray clk_en: nothing may happen.
      l0 = loads; s0 = steps; w0 = swaps;
      tick(50);
      check("idle_in_ready", in_ready, 1);
      check("idle_run", run, 0);
      check("idle_strobes", loads - l0 + steps - s0 + swaps - w0, 0);

      // Encrypt then decrypt with out_ready already high.
      for (int m = 0; m < 2; m++) begin
         out_ready = 1'b1;
         key_q.delete(); idx_q.delete();
         l0 = loads; w0 = swaps;
         submit(m[0]);
         wait_ov();
         tick(1);
         check("job_loads", loads - l0, 1);
         check("job_swaps", swaps - w0, 1);
         check("job_back_idle", in_ready, 1);
         check_seq(m[0]);
      end

      // Result held while out_ready is low, then a back-to-back job.
      out_ready = 1'b0;
      submit(1'b1);
      wait_ov();
      tick(20);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_run", run, 0);
      out_ready = 1'b1;
      tick(1);
      check("release_in_ready", in_ready, 1);
      out_ready = 1'b0;
      key_q.delete(); idx_q.delete();
      submit(1'b0);
      wait_ov();
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check_seq(1'b0);

      // Asynchronous reset in the middle of round 7.
      out_ready = 1'b1;
      submit(1'b1);
      n = 0;
      while (!(round_step && round_idx == CW'(7)) && n < 300) begin tick(1); n++; end
      check("reached_round7", round_idx, 7);
      #2;
      reset = 1'b1;
      #1;
      check("async_in_ready", in_ready, 1);
      check("async_run", run, 0);
      check("async_strobes", {load_blk, round_step, final_swap}, 0);
      check("async_out_valid", out_valid, 0);
      check("async_round_idx", round_idx, 0);
      tick(2);
      reset = 1'b0;
      key_q.delete(); idx_q.delete();
      submit(1'b0);
      wait_ov();
      tick(1);
      check_seq(1'b0);

      // in_valid stuck high with decrypt wiggling: one job per IDLE visit.
      l0 = loads; w0 = swaps;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      n = 0;
      while (swaps - w0 < 3 && n < 400) begin
         decrypt = ($urandom_range(0, 1) == 1);
         tick(1);
         n++;
      end
      check("stream_swaps", swaps - w0, 3);
      check("stream_loads", loads - l0, 3);
      in_valid = 1'b0;
      wait_ov();
      tick(2);

      // Random jobs with random out_ready backpressure.
      for (int j = 0; j < 6; j++) begin
         dec = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 1) == 1);
         key_q.delete(); idx_q.delete();
         submit(dec);
         wait_ov();
         n = 0;
         while (!out_ready && n < 50) begin
            out_ready = ($urandom_range(0, 3) == 0);
            n++;
            if (!out_ready) tick(1);
         end
         out_ready = 1'b1;
         tick(1);
         out_ready = 1'b0;
         check_seq(dec);
         tick($urandom_range(0, 5));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
